// File: rtl/mux_scan_ctrl_if.sv
// Handshake and mux-facing signals of the mux scan sequencer.
// The master side drives start/mask and the mux output y; the slave is the sequencer.
interface mux_scan_ctrl_if;
  logic       start;
  logic [3:0] mask;
  logic       y;
  logic       s1;
  logic       s0;
  logic [3:0] sample;
  logic       done;
  logic       busy;
  logic       changed;

  modport master (
    output start, mask, y,
    input  s1, s0, sample, done, busy, changed
  );

  modport slave (
    input  start, mask, y,
    output s1, s0, sample, done, busy, changed
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Steps a 4:1 mux through the enabled channels, dwelling DWELL cycles on each,
// and publishes the captured snapshot with a one-cycle done pulse.
//
// state | meaning
// IDLE  | select parked at 00, waiting for start
// SCAN  | select = ch, counting dwell before sampling y
module mux_scan_ctrl #(
  parameter int DWELL = 2
) (
  input logic            clk,
  input logic            rst,
  mux_scan_ctrl_if.slave bus
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [7:0] LAST = 8'(DWELL - 1);

  state_t     state;
  logic [1:0] ch;
  logic [7:0] cnt;
  logic [3:0] mreg;
  logic [3:0] shadow;
  logic [3:0] merged;
  logic [2:0] nxt;

  function automatic logic [1:0] lowest_bit(input logic [3:0] m);
    lowest_bit = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (m[i]) lowest_bit = 2'(i);
  endfunction

  // {found, index} of the nearest enabled channel strictly above c
  function automatic logic [2:0] next_above(input logic [3:0] m, input logic [1:0] c);
    next_above = 3'b000;
    for (int i = 3; i >= 0; i--)
      if (m[i] && (i > int'(c))) next_above = {1'b1, 2'(i)};
  endfunction

  assign nxt = next_above(mreg, ch);

  always_comb begin
    merged     = shadow;
    merged[ch] = bus.y;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ch          <= 2'd0;
      cnt         <= 8'd0;
      mreg        <= 4'd0;
      shadow      <= 4'd0;
      bus.s1      <= 1'b0;
      bus.s0      <= 1'b0;
      bus.sample  <= 4'd0;
      bus.done    <= 1'b0;
      bus.busy    <= 1'b0;
      bus.changed <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.mask != 4'd0) begin
              mreg              <= bus.mask;
              shadow            <= 4'd0;
              cnt               <= 8'd0;
              ch                <= lowest_bit(bus.mask);
              {bus.s1, bus.s0}  <= lowest_bit(bus.mask);
              bus.busy          <= 1'b1;
              state             <= SCAN;
            end else begin
              // empty scan completes immediately with an all-zero snapshot
              bus.sample  <= 4'd0;
              bus.done    <= 1'b1;
              bus.changed <= (bus.sample != 4'd0);
            end
          end
        end
        SCAN: begin
          if (cnt < LAST) begin
            cnt <= cnt + 8'd1;
          end else begin
            shadow <= merged;
            cnt    <= 8'd0;
            if (nxt[2]) begin
              ch               <= nxt[1:0];
              {bus.s1, bus.s0} <= nxt[1:0];
            end else begin
              bus.sample       <= merged;
              bus.done         <= 1'b1;
              bus.changed      <= (merged != bus.sample);
              bus.busy         <= 1'b0;
              {bus.s1, bus.s0} <= 2'b00;
              state            <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Lockstep bench for two sequencers (DWELL=2 and DWELL=1) against a
// scan-level reference model that derives timing from elapsed cycles.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_v = 1'b0;
  logic [3:0] mask_v = 4'd0;
  logic [3:0] mux_in = 4'd0;

  int n_err = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  mux_scan_ctrl_if if2 ();
  mux_scan_ctrl_if if1 ();

  assign if2.start = start_v;
  assign if2.mask  = mask_v;
  assign if2.y     = mux_in[{if2.s1, if2.s0}];
  assign if1.start = start_v;
  assign if1.mask  = mask_v;
  assign if1.y     = mux_in[{if1.s1, if1.s0}];

  mux_scan_ctrl #(.DWELL(2)) dut_d2 (.clk(clk), .rst(rst), .bus(if2.slave));
  mux_scan_ctrl #(.DWELL(1)) dut_d1 (.clk(clk), .rst(rst), .bus(if1.slave));

  // reference model, index 0 -> DWELL=2, index 1 -> DWELL=1
  bit         m_busy    [2];
  int         m_t       [2];
  int         m_kn      [2];
  int         m_chans   [2][4];
  logic [3:0] m_cap     [2];
  logic [3:0] m_sample  [2];
  bit         m_done    [2];
  bit         m_changed [2];

  function automatic int dwell_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic logic [1:0] exp_sel(input int i);
    if (!m_busy[i]) return 2'd0;
    return 2'(m_chans[i][m_t[i] / dwell_of(i)]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_t[i] = 0; m_kn[i] = 0; m_cap[i] = 4'd0;
      m_sample[i] = 4'd0; m_done[i] = 0; m_changed[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    int d;
    int k;
    int c;
    d = dwell_of(i);
    m_done[i] = 0;
    if (!m_busy[i]) begin
      if (start_v) begin
        if (mask_v != 4'd0) begin
          m_busy[i] = 1; m_t[i] = 0; m_kn[i] = 0; m_cap[i] = 4'd0;
          for (int n = 0; n < 4; n++)
            if (mask_v[n]) begin m_chans[i][m_kn[i]] = n; m_kn[i]++; end
        end else begin
          m_changed[i] = (m_sample[i] != 4'd0);
          m_sample[i]  = 4'd0;
          m_done[i]    = 1;
        end
      end
    end else begin
      m_t[i]++;
      if (m_t[i] % d == 0) begin
        k = m_t[i] / d;
        c = m_chans[i][k-1];
        m_cap[i][c] = mux_in[c];
        if (k == m_kn[i]) begin
          m_changed[i] = (m_cap[i] != m_sample[i]);
          m_sample[i]  = m_cap[i];
          m_done[i]    = 1;
          m_busy[i]    = 0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("d2_sel",     32'({if2.s1, if2.s0}), 32'(exp_sel(0)));
    chk("d2_sample",  32'(if2.sample),       32'(m_sample[0]));
    chk("d2_done",    32'(if2.done),         32'(m_done[0]));
    chk("d2_busy",    32'(if2.busy),         32'(m_busy[0]));
    chk("d2_changed", 32'(if2.changed),      32'(m_changed[0]));
    chk("d1_sel",     32'({if1.s1, if1.s0}), 32'(exp_sel(1)));
    chk("d1_sample",  32'(if1.sample),       32'(m_sample[1]));
    chk("d1_done",    32'(if1.done),         32'(m_done[1]));
    chk("d1_busy",    32'(if1.busy),         32'(m_busy[1]));
    chk("d1_changed", 32'(if1.changed),      32'(m_changed[1]));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    start_v = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    start_v = 1'b0;
    while ((m_busy[0] || m_busy[1]) && n < 50) begin
      cycle();
      n++;
    end
  endtask

  // latency counted in edges after the accepting edge until DUT(DWELL=2) shows done
  task automatic scan_lat(input logic [3:0] m, input logic [3:0] mv, input bit poke, output int lat);
    wait_idle();
    start_v = 1'b1; mask_v = m; mux_in = mv;
    cycle();
    start_v = 1'b0;
    mask_v  = 4'($urandom);
    lat = 0;
    while (!if2.done && lat < 40) begin
      if (poke && lat == 2) start_v = 1'b1;
      cycle();
      start_v = 1'b0;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int seen;

    model_reset();
    #2;
    do_reset();
    repeat (10) cycle();

    scan_lat(4'b1111, 4'b1101, 1'b0, lat);
    chk("full_lat", lat, 8);
    chk("full_sample", 32'(if2.sample), 32'h0000000d);
    chk("full_changed", 32'(if2.changed), 1);

    scan_lat(4'b1010, 4'b1101, 1'b0, lat);
    chk("masked_lat", lat, 4);
    chk("masked_sample", 32'(if2.sample), 32'h00000008);
    chk("masked_changed", 32'(if2.changed), 1);

    scan_lat(4'b1010, 4'b1101, 1'b0, lat);
    chk("repeat_changed", 32'(if2.changed), 0);

    scan_lat(4'b0000, 4'b1101, 1'b0, lat);
    chk("empty_lat", lat, 0);
    chk("empty_sample", 32'(if2.sample), 0);
    chk("empty_changed", 32'(if2.changed), 1);
    chk("empty_busy", 32'(if2.busy), 0);

    scan_lat(4'b1111, 4'b1101, 1'b1, lat);
    chk("ignore_start_lat", lat, 8);
    chk("ignore_start_sample", 32'(if2.sample), 32'h0000000d);

    wait_idle();
    start_v = 1'b1; mask_v = 4'b1111; mux_in = 4'($urandom);
    cycle();
    start_v = 1'b0;
    repeat (3) cycle();
    do_reset();
    chk("rst_sel", 32'({if2.s1, if2.s0}), 0);
    chk("rst_busy", 32'(if2.busy), 0);
    chk("rst_sample", 32'(if2.sample), 0);
    seen = 0;
    repeat (20) begin
      cycle();
      if (if2.done) seen++;
    end
    chk("rst_no_done", seen, 0);

    wait_idle();
    start_v = 1'b1; mask_v = 4'b1111; mux_in = 4'($urandom);
    cycle();
    lat = 0;
    while (!if1.done && lat < 40) begin cycle(); lat++; end
    chk("d1_lat", lat, 4);
    lat = 0;
    do begin cycle(); lat++; end while (!if1.done && lat < 40);
    chk("d1_b2b", lat, 5);
    start_v = 1'b0;

    repeat (800) begin
      start_v = ($urandom_range(0, 3) == 0);
      mask_v  = 4'($urandom);
      mux_in  = 4'($urandom);
      if ($urandom_range(0, 299) == 0) do_reset();
      else cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
